// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, one digit per clock, LSD first, with a start/done handshake.
// Optional feature macro BCD_SUB_EN adds i_sub for ten's-complement subtraction (A-B).
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    input  logic                  i_cin,
`ifdef BCD_SUB_EN
    input  logic                  i_sub,
`endif
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_sum,
    output logic                  o_carry,
    output logic                  o_err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LastDigit = CW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    b_eff;
    logic            c_init;
    logic            in_err;
    logic            accept;
    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [4:0]      raw;
    logic [3:0]      d_dig;
    logic            c_next;
    logic [W-1:0]    sum_next;

    function automatic logic any_invalid(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            r = r | (v[4*k +: 4] > 4'd9);
        end
        return r;
    endfunction

`ifdef BCD_SUB_EN
    // Nine's complement per digit; out-of-range digits simply wrap in 4 bits.
    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            r[4*k +: 4] = 4'd9 - v[4*k +: 4];
        end
        return r;
    endfunction

    assign b_eff  = i_sub ? nines(i_b) : i_b;
    assign c_init = i_sub | i_cin;
`else
    assign b_eff  = i_b;
    assign c_init = i_cin;
`endif

    assign in_err  = any_invalid(i_a) | any_invalid(i_b);
    assign accept  = i_start && (state != StAdd);
    assign o_ready = (state != StAdd);
    assign o_busy  = (state == StAdd);

    always_comb begin
        a_dig    = a_reg[4*cnt +: 4];
        b_dig    = b_reg[4*cnt +: 4];
        raw      = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_reg};
        d_dig    = raw[3:0];
        c_next   = 1'b0;
        if (raw > 5'd9) begin
            d_dig  = raw[3:0] + 4'd6;
            c_next = 1'b1;
        end
        sum_next              = sum_reg;
        sum_next[4*cnt +: 4]  = d_dig;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= StIdle;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            o_done    <= 1'b0;
            o_sum     <= '0;
            o_carry   <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (accept) begin
                        state     <= StAdd;
                        a_reg     <= i_a;
                        b_reg     <= b_eff;
                        sum_reg   <= '0;
                        carry_reg <= c_init;
                        cnt       <= '0;
                        o_err     <= in_err;
                    end else begin
                        state <= StIdle;
                    end
                end
                StAdd: begin
                    sum_reg   <= sum_next;
                    carry_reg <= c_next;
                    if (cnt == LastDigit) begin
                        state   <= StDone;
                        o_sum   <= sum_next;
                        o_carry <= c_next;
                        o_done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
